forward_scoreboard: RTL and testbench

FORWARD_SCOREBOARD -- requirements
Module: forward_scoreboard

---
 rtl/forward_scoreboard.sv | 111 +++++++++++
 tb/tb_forward_scoreboard.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/forward_scoreboard.sv
// Forwarding scoreboard: tracks destination registers of instructions past ID and
// picks, per ID read port, the youngest producing stage or raises a load-use stall.
module forward_scoreboard #(
   parameter  int AW         = 4,
   parameter  int NRD        = 2,
   parameter  int DEPTH      = 3,
   parameter  int LOAD_STAGE = 1,
   parameter  int ZERO_REG   = 0,
   localparam int SW         = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   input  logic [NRD*AW-1:0] id_src,
   input  logic [NRD-1:0]    id_src_used,
   input  logic              id_wr0_en,
   input  logic [AW-1:0]     id_wr0_addr,
   input  logic              id_wr1_en,
   input  logic [AW-1:0]     id_wr1_addr,
   input  logic              id_is_load,
   input  logic              flush,
   output logic [NRD*SW-1:0] fwd_sel,
   output logic [NRD-1:0]    fwd_slot,
   output logic              stall,
   output logic              issue,
   output logic [15:0]       stall_cnt
);

   typedef struct packed {
      logic          vld;
      logic          wr0_en;
      logic [AW-1:0] wr0_addr;
      logic          wr1_en;
      logic [AW-1:0] wr1_addr;
      logic          is_load;
   } entry_t;

   entry_t         r_ent [DEPTH];
   logic [15:0]    r_stall_cnt;

   logic [AW-1:0]    w_src      [NRD];
   logic [NRD-1:0]   w_src_live;
   logic [DEPTH-1:0] w_hit0     [NRD];
   logic [DEPTH-1:0] w_hit1     [NRD];
   logic [NRD-1:0]   w_port_hazard;
   logic             w_stall;
   logic             w_issue;
   entry_t           w_id_ent;

   always_comb begin
      for (int p = 0; p < NRD; p++) begin
         w_src[p]      = id_src[p*AW +: AW];
         w_src_live[p] = id_src_used[p] && !((ZERO_REG != 0) && (w_src[p] == '0));
      end
   end

   always_comb begin
      for (int p = 0; p < NRD; p++) begin
         w_hit0[p] = '0;
         w_hit1[p] = '0;
         for (int k = 0; k < DEPTH; k++) begin
            w_hit0[p][k] = w_src_live[p] && r_ent[k].vld && r_ent[k].wr0_en
                           && (r_ent[k].wr0_addr == w_src[p]);
            w_hit1[p][k] = w_src_live[p] && r_ent[k].vld && r_ent[k].wr1_en
                           && (r_ent[k].wr1_addr == w_src[p]);
         end
      end
   end

   // Walk oldest to youngest so the youngest match overwrites; slot 1 beats slot 0.
   always_comb begin
      fwd_sel       = '0;
      fwd_slot      = '0;
      w_port_hazard = '0;
      for (int p = 0; p < NRD; p++) begin
         for (int k = DEPTH - 1; k >= 0; k--) begin
            if (w_hit0[p][k] || w_hit1[p][k]) begin
               fwd_sel[p*SW +: SW] = SW'(k + 1);
               fwd_slot[p]         = w_hit1[p][k];
               w_port_hazard[p]    = (k < LOAD_STAGE) && r_ent[k].is_load;
            end
         end
      end
   end

   assign w_stall  = id_valid & ~flush & (|w_port_hazard);
   assign w_issue  = id_valid & ~flush & ~w_stall;
   assign w_id_ent = {1'b1, id_wr0_en, id_wr0_addr, id_wr1_en, id_wr1_addr, id_is_load};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_ent[i] <= entry_t'('0);
         end
         r_stall_cnt <= '0;
      end else begin
         r_ent[0] <= w_issue ? w_id_ent : entry_t'('0);
         for (int i = DEPTH - 1; i > 0; i--) begin
            r_ent[i] <= r_ent[i-1];
         end
         if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
         end
      end
   end

   assign stall     = w_stall;
   assign issue     = w_issue;
   assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_forward_scoreboard.sv
// Bench for forward_scoreboard: history-based reference model checked every cycle,
// directed literal cases, random traffic, and a deep-pipeline instance for counter saturation.
module tb_forward_scoreboard;
   localparam int AW = 4, NRD = 2, DEPTH = 3, LS = 1, ZR = 1, SW = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // main instance
   logic        rst_n, id_valid, id_wr0_en, id_wr1_en, id_is_load, flush;
   logic [7:0]  id_src;
   logic [1:0]  id_src_used;
   logic [3:0]  id_wr0_addr, id_wr1_addr;
   logic [3:0]  fwd_sel;
   logic [1:0]  fwd_slot;
   logic        stall, issue;
   logic [15:0] stall_cnt;

   forward_scoreboard #(.ZERO_REG(1)) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src(id_src),
      .id_src_used(id_src_used), .id_wr0_en(id_wr0_en), .id_wr0_addr(id_wr0_addr),
      .id_wr1_en(id_wr1_en), .id_wr1_addr(id_wr1_addr), .id_is_load(id_is_load),
      .flush(flush), .fwd_sel(fwd_sel), .fwd_slot(fwd_slot), .stall(stall),
      .issue(issue), .stall_cnt(stall_cnt)
   );

   // deep instance: every tracked stage is before the load-forward point
   logic        b_rst_n, b_id_valid, b_wr0_en, b_wr1_en, b_is_load, b_flush;
   logic [7:0]  b_src;
   logic [1:0]  b_used;
   logic [3:0]  b_wr0_addr, b_wr1_addr;
   logic [7:0]  b_fwd_sel;
   logic [1:0]  b_fwd_slot;
   logic        b_stall, b_issue;
   logic [15:0] b_stall_cnt;

   forward_scoreboard #(.DEPTH(15), .LOAD_STAGE(15)) dut_b (
      .clk(clk), .rst_n(b_rst_n), .id_valid(b_id_valid), .id_src(b_src),
      .id_src_used(b_used), .id_wr0_en(b_wr0_en), .id_wr0_addr(b_wr0_addr),
      .id_wr1_en(b_wr1_en), .id_wr1_addr(b_wr1_addr), .id_is_load(b_is_load),
      .flush(b_flush), .fwd_sel(b_fwd_sel), .fwd_slot(b_fwd_slot), .stall(b_stall),
      .issue(b_issue), .stall_cnt(b_stall_cnt)
   );

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         if (failures <= 30)
            $display("FAIL %s got=%0h expected=%0h at %0t", nm, got, exp, $time);
      end
   endtask

   // ---------------- reference model: list of what issued on recent cycles
   typedef struct {
      bit v; bit e0; int a0; bit e1; int a1; bit ld;
   } ent_t;

   ent_t hist[$];
   ent_t n_ent;
   int   m_cnt = 0;
   bit   m_ok = 0;
   bit   e_stall, e_issue, e_hz;
   int   e_sel [NRD];
   int   e_slot[NRD];

   function automatic void eval();
      int   src;
      bit   done, m0, m1;
      ent_t en;
      e_hz = 0;
      for (int p = 0; p < NRD; p++) begin
         src = int'(id_src[p*AW +: AW]);
         e_sel[p] = 0;
         e_slot[p] = 0;
         done = 0;
         if (id_src_used[p] && !(ZR == 1 && src == 0)) begin
            for (int k = 0; k < DEPTH; k++) begin
               if (!done && k < hist.size()) begin
                  en = hist[hist.size() - 1 - k];
                  m0 = en.v && en.e0 && (en.a0 == src);
                  m1 = en.v && en.e1 && (en.a1 == src);
                  if (m0 || m1) begin
                     done = 1;
                     e_sel[p] = k + 1;
                     e_slot[p] = m1 ? 1 : 0;
                     if (k < LS && en.ld) e_hz = 1;
                  end
               end
            end
         end
      end
      e_stall = id_valid && !flush && e_hz;
      e_issue = id_valid && !flush && !e_stall;
   endfunction

   initial begin
      forever begin
         @(negedge clk);
         if (m_ok) begin
            eval();
            chk("stall", stall, e_stall);
            chk("issue", issue, e_issue);
            chk("stall_cnt", stall_cnt, m_cnt);
            if (id_valid) begin
               for (int p = 0; p < NRD; p++) begin
                  chk("fwd_sel", fwd_sel[p*SW +: SW], e_sel[p]);
                  chk("fwd_slot", fwd_slot[p], e_slot[p]);
               end
            end
         end
         @(posedge clk);
         if (!rst_n) begin
            hist.delete();
            m_cnt = 0;
            m_ok = 1;
         end else if (m_ok) begin
            n_ent = '{default: 0};
            if (e_issue)
               n_ent = '{1, id_wr0_en, int'(id_wr0_addr), id_wr1_en, int'(id_wr1_addr), id_is_load};
            hist.push_back(n_ent);
            if (hist.size() > DEPTH) void'(hist.pop_front());
            if (e_stall && m_cnt < 65535) m_cnt++;
         end
      end
   end

   // ---------------- stimulus
   task automatic drv(input bit v, input int s0, input int s1, input bit [1:0] u,
                      input bit w0, input int a0, input bit w1, input int a1,
                      input bit ld, input bit fl);
      id_valid    = v;
      id_src      = {4'(s1), 4'(s0)};
      id_src_used = u;
      id_wr0_en   = w0;
      id_wr0_addr = 4'(a0);
      id_wr1_en   = w1;
      id_wr1_addr = 4'(a1);
      id_is_load  = ld;
      flush       = fl;
   endtask

   task automatic stp();
      @(posedge clk);
      #1;
   endtask

   int t;
   int b_exp;

   initial begin
      rst_n = 0;
      b_rst_n = 0;
      drv(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
      b_id_valid = 1; b_src = 8'h05; b_used = 2'b01; b_wr0_en = 1; b_wr0_addr = 4'd5;
      b_wr1_en = 0; b_wr1_addr = 4'd0; b_is_load = 1; b_flush = 0;
      repeat (3) @(posedge clk);
      #1;

      // reset state
      rst_n = 1;
      drv(1, 3, 5, 2'b11, 0, 0, 0, 0, 0, 0);
      #2;
      chk("rst_sel", fwd_sel, 0); chk("rst_stall", stall, 0);
      chk("rst_cnt", stall_cnt, 0); chk("rst_issue", issue, 1);
      stp();

      // ALU chain
      drv(1, 0, 0, 2'b00, 1, 3, 0, 0, 0, 0); #2; chk("alu_issue", issue, 1); stp();
      drv(1, 3, 0, 2'b01, 0, 0, 0, 0, 0, 0); #2;
      chk("alu_sel_ex", fwd_sel[1:0], 1); chk("alu_slot", fwd_slot[0], 0); chk("alu_stall", stall, 0);
      stp();
      #2; chk("alu_sel_mem", fwd_sel[1:0], 2); stp();

      // load-use
      drv(1, 0, 0, 2'b00, 1, 5, 0, 0, 1, 0); stp();
      drv(1, 0, 5, 2'b10, 0, 0, 0, 0, 0, 0); #2;
      chk("lu_stall", stall, 1); chk("lu_issue0", issue, 0); chk("lu_sel_ex", fwd_sel[3:2], 1);
      stp();
      #2;
      chk("lu_clear", stall, 0); chk("lu_sel_mem", fwd_sel[3:2], 2);
      chk("lu_issue1", issue, 1); chk("lu_cnt", stall_cnt, 1);
      stp();

      // swap
      drv(1, 0, 0, 2'b00, 1, 2, 1, 7, 0, 0); stp();
      drv(1, 7, 2, 2'b11, 0, 0, 0, 0, 0, 0); #2;
      chk("swap_sel0", fwd_sel[1:0], 1); chk("swap_slot0", fwd_slot[0], 1);
      chk("swap_sel1", fwd_sel[3:2], 1); chk("swap_slot1", fwd_slot[1], 0);
      stp();

      // both slots same address
      drv(1, 0, 0, 2'b00, 1, 6, 1, 6, 0, 0); stp();
      drv(1, 6, 0, 2'b01, 0, 0, 0, 0, 0, 0); #2;
      chk("dup_sel", fwd_sel[1:0], 1); chk("dup_slot", fwd_slot[0], 1);
      stp();

      // youngest wins, register 0 never matches
      drv(1, 0, 0, 2'b00, 1, 4, 0, 0, 0, 0); stp();
      drv(1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0); stp();
      drv(1, 0, 0, 2'b00, 1, 4, 1, 0, 0, 0); stp();
      drv(1, 4, 0, 2'b11, 0, 0, 0, 0, 0, 0); #2;
      chk("young_sel", fwd_sel[1:0], 1); chk("young_slot", fwd_slot[0], 0);
      chk("zero_sel", fwd_sel[3:2], 0);
      stp();

      // flush during hazard
      drv(1, 0, 0, 2'b00, 1, 9, 0, 0, 1, 0); stp();
      drv(1, 9, 0, 2'b01, 1, 1, 0, 0, 0, 1); #2;
      chk("fl_stall", stall, 0); chk("fl_issue", issue, 0);
      stp();
      drv(1, 1, 9, 2'b11, 0, 0, 0, 0, 0, 0); #2;
      chk("fl_bubble", fwd_sel[1:0], 0); chk("fl_load_mem", fwd_sel[3:2], 2);
      chk("fl_nostall", stall, 0); chk("fl_cnt", stall_cnt, 1);
      stp();

      // reset mid-stall
      drv(1, 0, 0, 2'b00, 1, 5, 0, 0, 1, 0); stp();
      drv(1, 5, 0, 2'b01, 0, 0, 0, 0, 0, 0); #2;
      chk("rs_stall", stall, 1);
      rst_n = 0;
      stp();
      rst_n = 1;
      #2;
      chk("rs_clear", stall, 0); chk("rs_issue", issue, 1);
      chk("rs_sel", fwd_sel[1:0], 0); chk("rs_cnt", stall_cnt, 0);
      stp();

      // random traffic on a narrow register range to force frequent matches
      for (int i = 0; i < 2000; i++) begin
         rst_n = ($urandom_range(0, 99) != 0);
         drv(1'($urandom_range(0, 9) != 0), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
             1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 9) == 0));
         stp();
      end
      rst_n = 1;
      drv(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
      stp();

      // saturation: self-dependent loads in a 15-stage window stall 15 of every 16 cycles
      b_rst_n = 1;
      t = 0;
      b_exp = 0;
      while (b_exp < 65545) begin
         #2;
         chk("sat_stall", b_stall, (t % 16) != 0);
         chk("sat_sel", b_fwd_sel[3:0], t % 16);
         chk("sat_cnt", b_stall_cnt, (b_exp > 65535) ? 65535 : b_exp);
         if ((t % 16) != 0) b_exp++;
         t++;
         stp();
      end
      #2;
      chk("sat_hold", b_stall_cnt, 16'hFFFF);
      b_rst_n = 0;
      stp();
      b_rst_n = 1;
      #2;
      chk("sat_rst_cnt", b_stall_cnt, 0); chk("sat_rst_sel", b_fwd_sel, 0);
      chk("sat_rst_stall", b_stall, 0);
      stp();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
